// File: rtl/derandomizer.sv
// derandomizer: strips a 15-bit additive scrambler (1 + x^14 + x^15) from a
// byte stream, one byte per clock, eight LFSR steps per accepted byte.
// Bursts are opened by burst_start with a per-burst seed and byte count.
// Build option: define DERAND_SKID_EN for a registered in_ready backed by a
// 2-entry skid buffer; otherwise in_ready is a combinational function of
// the state and the output handshake.
module derandomizer #(
  parameter int MAX_LEN_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [14:0]          rand_iv,
  input  logic                 burst_start,
  input  logic [MAX_LEN_W-1:0] burst_len,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 seq_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [MAX_LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [MAX_LEN_W-1:0] LEN_ONE  = MAX_LEN_W'(1);

  state_t               state_reg, state_next;
  logic [14:0]          lfsr_reg, lfsr_next;
  logic [MAX_LEN_W-1:0] count_reg, count_next;
  logic                 seq_err_reg, seq_err_next;

  logic                 accept;
  logic                 last_accept;
  logic                 out_fire;
  logic                 last_fire;

  // Eight unrolled LFSR steps; step 0 descrambles bit 7 (first on air).
  logic [14:0]          step_v [0:8];
  logic [7:0]           prbs_bit;
  logic [7:0]           dec_byte;
  logic [14:0]          lfsr_stepped;

  assign step_v[0] = lfsr_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_step
    assign prbs_bit[gi]      = step_v[gi][14] ^ step_v[gi][13];
    assign step_v[gi+1]      = {step_v[gi][13:0], prbs_bit[gi]};
    assign dec_byte[7-gi]    = in_data[7-gi] ^ prbs_bit[gi];
  end

  assign lfsr_stepped = step_v[8];

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (count_reg == LEN_ONE);
  assign out_fire    = out_valid && out_ready;
  assign last_fire   = out_fire && out_last;

  assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
  assign seq_err = seq_err_reg;

  // Next-state logic: burst open/close, LFSR advance on acceptance only,
  // and rejection of burst_start that arrives at the wrong time.
  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    count_next   = count_reg;
    seq_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (burst_start) begin
          if (burst_len != LEN_ZERO) begin
            lfsr_next  = rand_iv;
            count_next = burst_len;
            state_next = RUN;
          end else begin
            seq_err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (burst_start) begin
          seq_err_next = 1'b1;
        end
        if (accept) begin
          lfsr_next  = lfsr_stepped;
          count_next = count_reg - LEN_ONE;
          if (last_accept) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (burst_start) begin
          seq_err_next = 1'b1;
        end
        if (last_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      lfsr_reg    <= '0;
      count_reg   <= '0;
      seq_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      count_reg   <= count_next;
      seq_err_reg <= seq_err_next;
    end
  end

`ifdef DERAND_SKID_EN

  // Two-entry buffer; the head entry drives the outputs directly so an
  // empty buffer still gives one cycle from acceptance to out_valid.
  logic [7:0] buf_data_reg [0:1];
  logic       buf_last_reg [0:1];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] fill_reg, fill_next;
  logic       in_ready_reg, in_ready_next;

  assign in_ready  = in_ready_reg;
  assign out_valid = (fill_reg != 2'd0);
  assign out_data  = buf_data_reg[rd_ptr_reg];
  assign out_last  = out_valid && buf_last_reg[rd_ptr_reg];

  // Occupancy after this cycle's push/pop; ready is only promised when a
  // push next cycle cannot overflow regardless of out_ready then.
  always_comb begin
    fill_next = fill_reg;
    case ({accept, out_fire})
      2'b10:   fill_next = fill_reg + 2'd1;
      2'b01:   fill_next = fill_reg - 2'd1;
      default: fill_next = fill_reg;
    endcase
    in_ready_next = (state_next == RUN) && (fill_next <= 2'd1);
  end

  // Buffer entries are written only at the write pointer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        buf_data_reg[gi] <= '0;
        buf_last_reg[gi] <= 1'b0;
      end else if (accept && (wr_ptr_reg == 1'(gi))) begin
        buf_data_reg[gi] <= dec_byte;
        buf_last_reg[gi] <= last_accept;
      end
    end
  end

  // Pointer, occupancy and registered ready bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fill_reg     <= 2'd0;
      in_ready_reg <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (out_fire) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      fill_reg     <= fill_next;
      in_ready_reg <= in_ready_next;
    end
  end

`else

  // Single output register; upstream is stalled combinationally whenever
  // that register is occupied and not being drained this cycle.
  logic [7:0] out_data_reg;
  logic       out_valid_reg;
  logic       out_last_reg;

  assign in_ready  = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;

  // Load on acceptance, clear valid on a handshake with nothing behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_data_reg  <= dec_byte;
      out_valid_reg <= 1'b1;
      out_last_reg  <= last_accept;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_derandomizer.sv
// tb_derandomizer: cycle table for short directed bursts, then hand-written
// sequences for long bursts, stalls and mid-burst reset.
module tb_derandomizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rand_iv;
  logic        burst_start;
  logic [11:0] burst_len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        seq_err;

  int n_checks = 0;
  int n_miscompares = 0;

  logic [7:0] orig_mem [0:255];
  logic [7:0] scr_mem  [0:255];

  derandomizer #(.MAX_LEN_W(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .rand_iv     (rand_iv),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        bs;
    logic [11:0] len;
    logic [14:0] iv;
    logic        vld;
    logic [7:0]  din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic        e_busy;
    logic        e_serr;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [0:NVEC-1];

  function automatic vec_t mk(input logic bs, input logic [11:0] len, input logic [14:0] iv,
                              input logic vld, input logic [7:0] din, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                              input logic e_ol, input logic e_busy, input logic e_serr);
    vec_t v;
    v.bs = bs; v.len = len; v.iv = iv; v.vld = vld; v.din = din; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
    v.e_busy = e_busy; v.e_serr = e_serr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Random payload plus its bit-serial scrambled image for a given seed.
  task automatic prep_burst(input int len, input logic [14:0] seed);
    logic [14:0] s;
    logic        p;
    s = seed;
    for (int i = 0; i < len; i++) begin
      orig_mem[i] = 8'($urandom);
      for (int b = 7; b >= 0; b--) begin
        p = s[14] ^ s[13];
        s = {s[13:0], p};
        scr_mem[i][b] = orig_mem[i][b] ^ p;
      end
    end
  endtask

  // Push scr_mem through the DUT, expect orig_mem back in order.
  task automatic run_burst(input int len, input logic [14:0] seed, input bit stalls, input string tag);
    int         i_drv, cyc_drv, j, cyc_mon, gaps, last_hs;
    bit         acc, held;
    logic [7:0] hd;
    logic       hl;
    @(posedge clk); #1;
    burst_start = 1'b1; burst_len = 12'(len); rand_iv = seed; out_ready = 1'b1;
    @(posedge clk); #1;
    burst_start = 1'b0;
    fork
      begin
        i_drv = 0; cyc_drv = 0;
        while (i_drv < len && cyc_drv < 5000) begin
          in_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
          in_data  = scr_mem[i_drv];
          @(negedge clk);
          acc = in_valid && in_ready;
          @(posedge clk); #1;
          if (acc) i_drv++;
          cyc_drv++;
        end
        in_valid = 1'b0;
      end
      begin
        j = 0; cyc_mon = 0; gaps = 0; last_hs = -1; held = 1'b0; hd = '0; hl = 1'b0;
        while (j < len && cyc_mon < 5000) begin
          out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
          @(negedge clk);
          if (held) begin
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_data"}, 32'(out_data), 32'(hd));
            chk({tag, ".hold_last"}, 32'(out_last), 32'(hl));
          end
          if (out_valid) begin
            if (out_ready) begin
              chk($sformatf("%s.byte%0d", tag, j), 32'(out_data), 32'(orig_mem[j]));
              chk($sformatf("%s.last%0d", tag, j), 32'(out_last), 32'(j == len - 1));
              if (last_hs >= 0 && cyc_mon - last_hs != 1) gaps++;
              last_hs = cyc_mon;
              j++;
              held = 1'b0;
            end else begin
              held = 1'b1; hd = out_data; hl = out_last;
            end
          end
          @(posedge clk); #1;
          cyc_mon++;
        end
        chk({tag, ".bytes_out"}, 32'(j), 32'(len));
        if (!stalls) chk({tag, ".gap_cycles"}, 32'(gaps), 32'd0);
        out_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [14:0] seed_a;
    reset = 1'b1; burst_start = 1'b0; burst_len = '0; rand_iv = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;

    vecs[0]  = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    // seed 0x4000, len 2: 0x80,0x03 descramble to 0x00,0x00
    vecs[1]  = mk(1, 2, 15'h4000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    vecs[2]  = mk(0, 0, 15'h0000, 1, 8'h80, 1,  1, 0, 8'h00, 0, 1, 0);
    vecs[3]  = mk(0, 0, 15'h0000, 1, 8'h03, 1,  1, 1, 8'h00, 0, 1, 0);
    vecs[4]  = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 1, 8'h00, 1, 1, 0);
    vecs[5]  = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    // zero seed passes data through; one out_ready stall in the middle
    vecs[6]  = mk(1, 4, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    vecs[7]  = mk(0, 0, 15'h0000, 1, 8'h12, 1,  1, 0, 8'h00, 0, 1, 0);
    vecs[8]  = mk(0, 0, 15'h0000, 1, 8'h34, 1,  1, 1, 8'h12, 0, 1, 0);
    vecs[9]  = mk(0, 0, 15'h0000, 1, 8'h56, 0,  0, 1, 8'h34, 0, 1, 0);
    vecs[10] = mk(0, 0, 15'h0000, 1, 8'h56, 1,  1, 1, 8'h34, 0, 1, 0);
    vecs[11] = mk(0, 0, 15'h0000, 1, 8'h78, 1,  1, 1, 8'h56, 0, 1, 0);
    vecs[12] = mk(0, 0, 15'h0000, 0, 8'h00, 0,  0, 1, 8'h78, 1, 1, 0);
    vecs[13] = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 1, 8'h78, 1, 1, 0);
    vecs[14] = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    // zero length in IDLE rejected
    vecs[15] = mk(1, 0, 15'h1234, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    vecs[16] = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 1);
    // burst_start mid-RUN rejected; seed/count of running burst untouched
    vecs[17] = mk(1, 3, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
    vecs[18] = mk(0, 0, 15'h0000, 1, 8'hA1, 1,  1, 0, 8'h00, 0, 1, 0);
    vecs[19] = mk(1, 5, 15'h7FFF, 1, 8'hB2, 1,  1, 1, 8'hA1, 0, 1, 0);
    vecs[20] = mk(0, 0, 15'h0000, 1, 8'hC3, 1,  1, 1, 8'hB2, 0, 1, 1);
    vecs[21] = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 1, 8'hC3, 1, 1, 0);
    vecs[22] = mk(0, 0, 15'h0000, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);

    #3;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_last", 32'(out_last), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.seq_err", 32'(seq_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      burst_start = vecs[i].bs; burst_len = vecs[i].len; rand_iv = vecs[i].iv;
      in_valid = vecs[i].vld; in_data = vecs[i].din; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("vec%0d.out_last", i), 32'(out_last), 32'(vecs[i].e_ol));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.seq_err", i), 32'(seq_err), 32'(vecs[i].e_serr));
      @(posedge clk); #1;
    end
    burst_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // long burst, full rate
    seed_a = 15'($urandom);
    prep_burst(200, seed_a);
    run_burst(200, seed_a, 1'b0, "len200");

    // same 64-byte payload without and with stalls
    seed_a = 15'($urandom);
    prep_burst(64, seed_a);
    run_burst(64, seed_a, 1'b0, "len64");
    run_burst(64, seed_a, 1'b1, "len64stall");

    // reset after 3 of 10 bytes, with the third byte held on the output
    seed_a = 15'($urandom);
    prep_burst(10, seed_a);
    @(posedge clk); #1;
    burst_start = 1'b1; burst_len = 12'd10; rand_iv = seed_a; out_ready = 1'b1;
    @(posedge clk); #1;
    burst_start = 1'b0; in_valid = 1'b1; in_data = scr_mem[0];
    @(posedge clk); #1;
    in_data = scr_mem[1];
    @(negedge clk);
    chk("rstmid.byte0", 32'(out_data), 32'(orig_mem[0]));
    @(posedge clk); #1;
    in_data = scr_mem[2];
    @(negedge clk);
    chk("rstmid.byte1", 32'(out_data), 32'(orig_mem[1]));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rstmid.byte2", 32'(out_data), 32'(orig_mem[2]));
    chk("rstmid.valid_held", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid.in_ready", 32'(in_ready), 32'd0);
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.out_data", 32'(out_data), 32'd0);
    chk("rstmid.out_last", 32'(out_last), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.seq_err", 32'(seq_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d.out_valid", c), 32'(out_valid), 32'd0);
      chk($sformatf("postrst%0d.out_last", c), 32'(out_last), 32'd0);
      chk($sformatf("postrst%0d.busy", c), 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    prep_burst(5, 15'h5A3C);
    run_burst(5, 15'h5A3C, 1'b0, "afterrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule

// File: doc/derandomizer.md
DERANDOMIZER -- requirements
Module: derandomizer

Interface
REQ-001 Parameter: MAX_LEN_W, default 12, width of the burst byte-length field and counter.
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 rand_iv  input  15  per-burst LFSR seed, sampled on burst_start.
REQ-005 burst_start  input  1  one-cycle pulse that opens a burst.
REQ-006 burst_len  input  MAX_LEN_W  number of bytes in the burst, sampled on burst_start.
REQ-007 in_data  input  8  randomized byte; bit 7 is the first bit on air.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_data  output  8  derandomized byte.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_last  output  1  qualifies the final byte of the burst.
REQ-014 busy  output  1  high in RUN and DRAIN states.
REQ-015 seq_err  output  1  one-cycle pulse flagging a rejected burst_start.

Function
REQ-016 The LFSR shall be 15 bits, polynomial 1+x^14+x^15: per bit, prbs = v[14]^v[13]; v shifts up by one; v[0] takes prbs.
REQ-017 Each accepted byte shall consume 8 LFSR steps in one clock, MSB first: out bit (7-k) = in bit (7-k) ^ prbs of step k.
REQ-018 The states shall be IDLE, RUN and DRAIN.
REQ-019 IDLE: in_ready=0; burst_start with burst_len!=0 loads v=rand_iv, count=burst_len, -> RUN.
REQ-020 IDLE: burst_start with burst_len==0 shall pulse seq_err and stay in IDLE.
REQ-021 RUN/DRAIN: burst_start shall be ignored, shall pulse seq_err, and shall not alter v or count.
REQ-022 A byte is accepted when in_valid && in_ready; count decrements; the accepted byte appears on out_data with out_valid high the next cycle (latency 1).
REQ-023 Acceptance with count==1 shall mark that byte out_last=1 and move RUN -> DRAIN; no further bytes are accepted.
REQ-024 DRAIN -> IDLE occurs when the last byte handshakes (out_valid && out_ready && out_last).
REQ-025 out_data, out_last and out_valid shall hold stable while out_valid && !out_ready.
REQ-026 Full throughput: one byte per clock when in_valid and out_ready are held high.
REQ-027 The LFSR shall advance only on acceptance; in_valid gaps shall not advance it.
REQ-028 An all-zero seed shall give an all-zero PRBS, so output = input.

Reset
REQ-029 On reset: state=IDLE, v=0, count=0, out_data=0, out_valid=0, out_last=0, in_ready=0, busy=0, seq_err=0.
REQ-030 Reset mid-burst shall discard the burst, including any held output byte; no out_last shall be emitted.

Configuration
REQ-031 Macro DERAND_SKID_EN shall select the input-side ready scheme.
REQ-032 With DERAND_SKID_EN defined: 2-entry skid buffer; in_ready is a register with no combinational path from out_ready; throughput per REQ-026 is kept.
REQ-033 Without DERAND_SKID_EN: no skid buffer; in_ready = (state==RUN) && (!out_valid || out_ready), combinational.
REQ-034 Latency per REQ-022 shall apply when the skid buffer is empty; the byte order and LFSR sequence shall be identical in both builds.

Verification
REQ-035 Seed 0x4000, len 2, in 0x80,0x03 -> out 0x00,0x00; out_last on 2nd byte only; back in IDLE after its handshake.
REQ-036 Seed 0x0000, len 4, in 0x12,0x34,0x56,0x78 -> out identical bytes.
REQ-037 Random seed and data, len 200, through a bit-serial scrambler model then derandomizer -> original bytes, one byte per clock.
REQ-038 Random in_valid gaps and out_ready stalls, len 64 -> same output as REQ-037 with a stall-free run; data stable while stalled.
REQ-039 burst_start with len 0 in IDLE and burst_start mid-RUN -> seq_err pulse each; the active burst output is unaffected.
REQ-040 Reset asserted after 3 of 10 bytes -> all outputs return to REQ-029 values; a new burst then decodes correctly from its seed.
